ex_mem_buffer: RTL and testbench

EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

---
 rtl/ex_mem_pkg.sv | 37 +++
 rtl/skid_buffer.sv | 58 +++++
 rtl/ex_mem_buffer.sv | 85 ++++++++
 tb/tb_ex_mem_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ==== ex_mem_pkg : shared EX/MEM entry type, ctrl bit indices, funct3 codes ====
// ==== rev 1.0                                                                ====
package ex_mem_pkg;

  // Field widths of a buffered entry; the top-level width parameters default to these.
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_FUNCT3_LSB = 5;

  localparam logic [2:0] FUNCT3_BYTE = 3'b000;
  localparam logic [2:0] FUNCT3_HALF = 3'b001;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic [7:0]        ctrl;
    logic              misaligned;
  } entry_t;

  // Unsigned variants share the low two funct3 bits, so only those are decoded.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    if (funct3[1:0] == FUNCT3_WORD[1:0]) return addr != 2'b00;
    if (funct3[1:0] == FUNCT3_HALF[1:0]) return addr[0];
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ==== skid_buffer : 2-entry in-order FIFO (head + skid), registered in_ready ====
// ==== rev 1.0                                                                 ====
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;
  T           skid_q;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);

  always_comb begin
    count_next = count;
    if (flush)              count_next = 2'd0;
    else if (push && !pop)  count_next = count + 2'd1;
    else if (pop && !push)  count_next = count - 2'd1;
  end

  // out_data is the head register; it only moves on a pop or on a push into an empty buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= 2'd0;
      in_ready <= 1'b1;
      out_data <= '0;
      skid_q   <= '0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (!flush) begin
        if (pop) begin
          if (count == 2'd2) out_data <= skid_q;
          else if (push)     out_data <= in_data;
        end else if (push) begin
          if (count == 2'd0) out_data <= in_data;
          else               skid_q   <= in_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_buffer.sv
`default_nettype none
// ==== ex_mem_buffer : EX/MEM pipeline buffer with branch redirect and misalign flag ====
// ==== rev 1.0                                                                      ====
module ex_mem_buffer
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int REG_ADDR_WIDTH = REG_AW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [7:0]                in_ctrl,
  input  logic [DATA_WIDTH-1:0]     in_branch_target,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_alu_result,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [7:0]                out_ctrl,
  output logic                      out_misaligned,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc
);

  logic   accept;
  logic   is_mem;
  logic   enqueue;
  logic   taken;
  entry_t in_entry;
  entry_t head;

  assign accept  = in_valid && in_ready && !flush;
  assign is_mem  = in_ctrl[CTRL_MEM_READ] || in_ctrl[CTRL_MEM_WRITE];
  // Entries with no register or memory side effect (pure branches) never reach MEM.
  assign enqueue = accept && (in_ctrl[CTRL_REG_WRITE] || is_mem);
  assign taken   = accept && in_ctrl[CTRL_BRANCH] && in_alu_result[0];

  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = in_alu_result;
    in_entry.store_data = in_store_data;
    in_entry.rd         = in_rd;
    in_entry.ctrl       = in_ctrl;
    in_entry.misaligned = is_mem &&
                          is_misaligned(in_ctrl[CTRL_FUNCT3_LSB +: 3], in_alu_result[1:0]);
  end

  skid_buffer #(
    .T (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (enqueue),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_alu_result = head.alu_result;
  assign out_store_data = head.store_data;
  assign out_rd         = head.rd;
  assign out_ctrl       = head.ctrl;
  assign out_misaligned = head.misaligned;

  always_ff @(posedge clk) begin
    if (!reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= taken;
      if (taken) redirect_pc <= in_branch_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_buffer.sv
`default_nettype none
// ==== tb_ex_mem_buffer : scoreboard bench for ex_mem_buffer ====
// ==== rev 1.0                                                ====
`timescale 1ns/1ps
module tb_ex_mem_buffer;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_store_data = '0;
  logic [31:0] in_branch_target = '0;
  logic [4:0]  in_rd = '0;
  logic [7:0]  in_ctrl = '0;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic        out_misaligned;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ex_mem_buffer #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .in_branch_target(in_branch_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .out_misaligned(out_misaligned),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  exp_t        q[$];
  logic        m_ready = 1'b1;
  logic        m_redir = 1'b0;
  logic        m_acc = 1'b0;
  logic        m_zero = 1'b0;
  logic        started = 1'b0;
  logic [31:0] m_rpc = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_mis(input logic [7:0] c, input logic [31:0] a);
    if (!(c[1] || c[2])) return 1'b0;
    case (c[6:5])
      2'b10:   return (a % 4) != 0;
      2'b01:   return (a % 2) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: updated on every rising edge from the inputs the bench drives.
  always @(posedge clk) begin
    exp_t e;
    m_acc = 1'b0;
    if (!reset) begin
      q.delete();
      m_ready = 1'b1; m_redir = 1'b0; m_rpc = '0; m_zero = 1'b1; started = 1'b1;
    end else if (flush) begin
      q.delete();
      m_ready = 1'b1; m_redir = 1'b0;
    end else begin
      m_acc = in_valid && m_ready;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (m_acc && (in_ctrl[0] || in_ctrl[1] || in_ctrl[2])) begin
        e.alu = in_alu_result; e.sd = in_store_data; e.rd = in_rd;
        e.ctrl = in_ctrl; e.mis = exp_mis(in_ctrl, in_alu_result);
        q.push_back(e);
        m_zero = 1'b0;
      end
      m_redir = m_acc && in_ctrl[4] && in_alu_result[0];
      if (m_redir) begin
        m_rpc = in_branch_target;
        m_zero = 1'b0;
      end
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, m_ready);
      check("redirect_valid", redirect_valid, m_redir);
      if (m_redir) check("redirect_pc", redirect_pc, m_rpc);
      if (q.size() != 0) begin
        check("out_alu_result", out_alu_result, q[0].alu);
        check("out_store_data", out_store_data, q[0].sd);
        check("out_rd", out_rd, q[0].rd);
        check("out_ctrl", out_ctrl, q[0].ctrl);
        check("out_misaligned", out_misaligned, q[0].mis);
      end
      if (m_zero) begin
        check("rst_alu", out_alu_result, 0);
        check("rst_sd", out_store_data, 0);
        check("rst_rd", out_rd, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_mis", out_misaligned, 0);
        check("rst_rpc", redirect_pc, 0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] tgt, input logic [4:0] rd, input logic [7:0] c);
    in_valid = v; in_alu_result = alu; in_store_data = sd;
    in_branch_target = tgt; in_rd = rd; in_ctrl = c;
  endtask

  // Presents one entry and holds it until the model sees it accepted.
  task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] tgt,
                      input logic [4:0] rd, input logic [7:0] c);
    set_in(1'b1, alu, sd, tgt, rd, c);
    last_wait = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      last_wait++;
      if (m_acc) break;
    end
    if (!m_acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  localparam logic [7:0] C_ALU   = 8'h01;
  localparam logic [7:0] C_LW    = 8'h4B;
  localparam logic [7:0] C_SW    = 8'h44;
  localparam logic [7:0] C_SH    = 8'h24;
  localparam logic [7:0] C_BR    = 8'h10;

  initial begin
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    out_ready = 1'b1;
    step();

    // Single ALU entry, one-cycle latency
    send(32'h10, 32'h0, 32'h0, 5'd3, C_ALU);
    check("t034_valid", out_valid, 1);
    check("t034_alu", out_alu_result, 32'h10);
    check("t034_rd", out_rd, 3);
    step();
    check("t034_drain", out_valid, 0);

    // Back-pressure with three loads
    out_ready = 1'b0;
    send(32'h100, 32'h0, 32'h0, 5'd1, C_LW);
    send(32'h104, 32'h0, 32'h0, 5'd2, C_LW);
    check("t035_full", in_ready, 0);
    set_in(1'b1, 32'h108, 32'h0, 32'h0, 5'd4, C_LW);
    step(2);
    check("t035_hold", out_alu_result, 32'h100);
    check("t035_still_full", in_ready, 0);
    out_ready = 1'b1;
    send(32'h108, 32'h0, 32'h0, 5'd4, C_LW);
    step(3);
    check("t035_empty", out_valid, 0);

    // Throughput: one per cycle with out_ready high
    for (int i = 0; i < 6; i++) begin
      send($urandom, $urandom, 32'h0, 5'(i + 8), C_ALU);
      check("t021_tput", last_wait, 1);
      check("t021_valid", out_valid, 1);
    end

    // Taken and not-taken branches
    send(32'h1, 32'h0, 32'h40, 5'd0, C_BR);
    check("t036_redir", redirect_valid, 1);
    check("t036_pc", redirect_pc, 32'h40);
    check("t036_noenq", out_valid, 0);
    step();
    check("t036_pulse", redirect_valid, 0);
    send(32'h0, 32'h0, 32'h40, 5'd0, C_BR);
    check("t036_nt", redirect_valid, 0);
    step();

    // Misalignment
    out_ready = 1'b0;
    send(32'h6, 32'hDEADBEEF, 32'h0, 5'd0, C_SW);
    check("t037_sw", out_misaligned, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(32'h6, 32'h1234, 32'h0, 5'd0, C_SH);
    check("t037_sh", out_misaligned, 0);
    out_ready = 1'b1;
    step();

    // Flush while full with a taken branch presented
    out_ready = 1'b0;
    send(32'h200, 32'h0, 32'h0, 5'd5, C_LW);
    send(32'h204, 32'h0, 32'h0, 5'd6, C_LW);
    set_in(1'b1, 32'h1, 32'h0, 32'h80, 5'd0, C_BR);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t038_valid", out_valid, 0);
    check("t038_ready", in_ready, 1);
    check("t038_redir", redirect_valid, 0);
    // Flush with room left: the taken branch would otherwise be accepted
    send(32'h300, 32'h0, 32'h0, 5'd7, C_LW);
    set_in(1'b1, 32'h1, 32'h0, 32'h90, 5'd0, C_BR);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t038_redir2", redirect_valid, 0);
    check("t038_valid2", out_valid, 0);

    // Reset with the buffer full
    send(32'h400, 32'h0, 32'h0, 5'd9, C_LW);
    send(32'h404, 32'h0, 32'h0, 5'd10, C_LW);
    reset = 1'b0;
    step();
    check("t039_valid", out_valid, 0);
    check("t039_ready", in_ready, 1);
    check("t039_alu", out_alu_result, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    send(32'h55, 32'h0, 32'h0, 5'd7, C_ALU);
    check("t039_after", out_alu_result, 32'h55);
    step();

    // Random traffic including flushes
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             5'($urandom), 8'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
